// File: rtl/sys1_clkgen_frac.sv
// Master clock generator: free-running binary divider plus NCH NUM/DEN fractional-rate channels.
// Optional runtime ratio reprogramming is enabled with `define SYS1_CLKGEN_RUNTIME_RATIO_EN.
module sys1_clkgen_frac #(
  parameter int NCH   = 4,
  parameter int ACC_W = 12,
  parameter int DIV_W = 5,
  parameter logic [NCH*ACC_W-1:0] NUM_VEC = {NCH{ACC_W'(1)}},
  parameter logic [NCH*ACC_W-1:0] DEN_VEC = {NCH{ACC_W'(3)}},
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk48M,
  input  logic             reset,
  input  logic             sync,
  input  logic [NCH-1:0]   hold,
  output logic [DIV_W-1:0] div_out,
  output logic [NCH-1:0]   ce,
  output logic [NCH-1:0]   clk_out,
  input  logic             cfg_wr,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [ACC_W-1:0] cfg_num,
  input  logic [ACC_W-1:0] cfg_den,
  output logic             cfg_busy
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [NCH-1:0]   ce_q, ce_d;
  logic [NCH-1:0]   clk_q, clk_d;
  logic [NCH-1:0]   dis;
  logic [ACC_W-1:0] acc_q [NCH];
  logic [ACC_W-1:0] acc_d [NCH];
  logic [ACC_W-1:0] num_q [NCH];
  logic [ACC_W-1:0] num_d [NCH];
  logic [ACC_W-1:0] den_q [NCH];
  logic [ACC_W-1:0] den_d [NCH];
  logic [ACC_W:0]   sum   [NCH];
  logic             busy_q, busy_d;

`ifdef SYS1_CLKGEN_RUNTIME_RATIO_EN
  logic [CH_W-1:0]  sh_ch_q, sh_ch_d;
  logic [ACC_W-1:0] sh_num_q, sh_num_d;
  logic [ACC_W-1:0] sh_den_q, sh_den_d;
  logic             sh_ok_q, sh_ok_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_wr, cfg_ch, cfg_num, cfg_den};
`endif

  always_comb begin
    div_d = sync ? '0 : div_q + DIV_W'(1);
    ce_d  = '0;
    clk_d = clk_q;
    dis   = '0;
    for (int i = 0; i < NCH; i++) begin
      acc_d[i] = acc_q[i];
      num_d[i] = num_q[i];
      den_d[i] = den_q[i];
      sum[i]   = {1'b0, acc_q[i]} + {1'b0, num_q[i]};
      dis[i]   = (num_q[i] == '0) || (den_q[i] == '0);
      if (sync) begin
        acc_d[i] = '0;
        clk_d[i] = 1'b0;
      end else if (hold[i] || dis[i]) begin
        acc_d[i] = acc_q[i];
      end else if (num_q[i] >= den_q[i]) begin
        // Ratio of one or more saturates to an enable on every cycle.
        acc_d[i] = '0;
        ce_d[i]  = 1'b1;
        clk_d[i] = ~clk_q[i];
      end else if (sum[i] >= {1'b0, den_q[i]}) begin
        acc_d[i] = ACC_W'(sum[i] - {1'b0, den_q[i]});
        ce_d[i]  = 1'b1;
        clk_d[i] = ~clk_q[i];
      end else begin
        acc_d[i] = sum[i][ACC_W-1:0];
      end
    end

`ifdef SYS1_CLKGEN_RUNTIME_RATIO_EN
    busy_d   = busy_q;
    sh_ch_d  = sh_ch_q;
    sh_num_d = sh_num_q;
    sh_den_d = sh_den_q;
    sh_ok_d  = sh_ok_q;
    if (busy_q) begin
      if (!sh_ok_q) begin
        busy_d = 1'b0;
      end else if (sync || hold[sh_ch_q] || dis[sh_ch_q] || ce_d[sh_ch_q]) begin
        // Swap ratio on the channel's own pulse so no partial period is emitted.
        num_d[sh_ch_q] = sh_num_q;
        den_d[sh_ch_q] = sh_den_q;
        acc_d[sh_ch_q] = '0;
        busy_d         = 1'b0;
      end
    end else if (cfg_wr) begin
      busy_d   = 1'b1;
      sh_ch_d  = cfg_ch;
      sh_num_d = cfg_num;
      sh_den_d = cfg_den;
      sh_ok_d  = (32'(cfg_ch) < NCH);
    end
`else
    busy_d = 1'b0;
`endif
  end

  always_ff @(posedge clk48M or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      ce_q   <= '0;
      clk_q  <= '0;
      busy_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= '0;
        num_q[i] <= NUM_VEC[i*ACC_W +: ACC_W];
        den_q[i] <= DEN_VEC[i*ACC_W +: ACC_W];
      end
`ifdef SYS1_CLKGEN_RUNTIME_RATIO_EN
      sh_ch_q  <= '0;
      sh_num_q <= '0;
      sh_den_q <= '0;
      sh_ok_q  <= 1'b0;
`endif
    end else begin
      div_q  <= div_d;
      ce_q   <= ce_d;
      clk_q  <= clk_d;
      busy_q <= busy_d;
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= acc_d[i];
        num_q[i] <= num_d[i];
        den_q[i] <= den_d[i];
      end
`ifdef SYS1_CLKGEN_RUNTIME_RATIO_EN
      sh_ch_q  <= sh_ch_d;
      sh_num_q <= sh_num_d;
      sh_den_q <= sh_den_d;
      sh_ok_q  <= sh_ok_d;
`endif
    end
  end

  assign div_out  = div_q;
  assign ce       = ce_q;
  assign clk_out  = clk_q;
  assign cfg_busy = busy_q;

endmodule
